// File: rtl/trng_health_monitor_if.sv
// rtl/trng_health_monitor_if.sv - generator word input and buffered output stream bundle
interface trng_health_monitor_if;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/trng_health_monitor.sv
// rtl/trng_health_monitor.sv - TRNG repetition/adaptive-proportion health monitor with output FIFO
module trng_health_monitor #(
    parameter int RCT_CUTOFF    = 4,
    parameter int APT_WINDOW    = 64,
    parameter int APT_CUTOFF    = 8,
    parameter int STARTUP_WORDS = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    trng_health_monitor_if.slave   bus,
    input  logic                   clear_alarm,
    output logic                   alarm,
    output logic [1:0]             alarm_cause,
    output logic                   healthy,
    output logic [7:0]             overflow_cnt
);
    localparam int RCW = $clog2(RCT_CUTOFF + 1);
    localparam int AIW = $clog2(APT_WINDOW);
    localparam int ACW = $clog2(APT_WINDOW + 1);
    localparam int SUW = $clog2(STARTUP_WORDS + 1);
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {ST_STARTUP, ST_RUN, ST_ALARM} state_t;
    state_t state, state_next;

    logic [15:0]    rct_last;
    logic           rct_have;
    logic [RCW-1:0] rct_cnt, rct_cnt_next;
    logic [AIW-1:0] apt_idx;
    logic [15:0]    apt_ref;
    logic [ACW-1:0] apt_cnt, apt_cnt_next;
    logic [SUW-1:0] su_cnt;
    logic           accept, restart, rct_fail, apt_fail, fail;
    logic           run_pass, push, pop, drop, full;
    logic [15:0]    mem [FIFO_DEPTH];
    logic [PW-1:0]  rd_ptr, wr_ptr;
    logic [CW-1:0]  count;

    // Words are only looked at outside ALARM; clear only matters while alarmed
    assign accept  = bus.in_valid && (state != ST_ALARM);
    assign restart = (state == ST_ALARM) && clear_alarm;

    // Both tests judge the incoming word on their post-update counts
    always_comb begin
        rct_cnt_next = (rct_have && (bus.in_data == rct_last)) ? rct_cnt + RCW'(1) : RCW'(1);
        apt_cnt_next = (apt_idx == '0) ? ACW'(1) : apt_cnt + ACW'(bus.in_data == apt_ref);
        rct_fail     = accept && (rct_cnt_next == RCW'(RCT_CUTOFF));
        apt_fail     = accept && (apt_cnt_next == ACW'(APT_CUTOFF));
        fail         = rct_fail || apt_fail;
    end

    // FIFO occupancy decisions use the registered count only
    assign full     = (count == CW'(FIFO_DEPTH));
    assign run_pass = accept && !fail && (state == ST_RUN);
    assign push     = run_pass && !full;
    assign drop     = run_pass && full;
    assign pop      = bus.out_valid && bus.out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_STARTUP;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_STARTUP: begin
                if (fail)
                    state_next = ST_ALARM;
                else if (accept && (su_cnt == SUW'(STARTUP_WORDS - 1)))
                    state_next = ST_RUN;
            end
            ST_RUN:   if (fail) state_next = ST_ALARM;
            ST_ALARM: if (clear_alarm) state_next = ST_STARTUP;
            default:  state_next = ST_STARTUP;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        healthy = (state == ST_RUN);
        alarm   = (state == ST_ALARM);
    end

    // Test history and startup progress; frozen in ALARM, wiped on restart
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || restart) begin
            rct_last <= '0;
            rct_have <= 1'b0;
            rct_cnt  <= '0;
            apt_idx  <= '0;
            apt_ref  <= '0;
            apt_cnt  <= '0;
            su_cnt   <= '0;
        end else if (accept) begin
            rct_last <= bus.in_data;
            rct_have <= 1'b1;
            rct_cnt  <= rct_cnt_next;
            apt_idx  <= apt_idx + AIW'(1);
            apt_cnt  <= apt_cnt_next;
            if (apt_idx == '0) apt_ref <= bus.in_data;
            if ((state == ST_STARTUP) && !fail) su_cnt <= su_cnt + SUW'(1);
        end
    end

    // Failure cause is captured with the alarm and dropped on restart
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       alarm_cause <= 2'b00;
        else if (restart) alarm_cause <= 2'b00;
        else if (fail)    alarm_cause <= {apt_fail, rct_fail};
    end

    // Dropped-word counter survives alarms; only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          overflow_cnt <= 8'd0;
        else if (drop && overflow_cnt != 8'hFF) overflow_cnt <= overflow_cnt + 8'd1;
    end

    // FIFO pointers and occupancy; a failure flushes everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || fail) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // FIFO storage needs no reset; the head is masked while empty
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.in_data;
    end

    assign bus.out_valid = (count != '0);
    assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : 16'h0000;
endmodule

// File: tb/tb_trng_health_monitor.sv
// tb/tb_trng_health_monitor.sv - randomized self-checking bench for trng_health_monitor
module tb_trng_health_monitor;
    localparam int RCT = 4;
    localparam int AW  = 64;
    localparam int AC  = 8;
    localparam int SW  = 16;
    localparam int FD  = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear_alarm;
    logic        alarm;
    logic [1:0]  alarm_cause;
    logic        healthy;
    logic [7:0]  overflow_cnt;

    trng_health_monitor_if bus_if();

    trng_health_monitor #(
        .RCT_CUTOFF(RCT), .APT_WINDOW(AW), .APT_CUTOFF(AC),
        .STARTUP_WORDS(SW), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus_if), .clear_alarm(clear_alarm),
        .alarm(alarm), .alarm_cause(alarm_cause), .healthy(healthy), .overflow_cnt(overflow_cnt)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: 0=STARTUP 1=RUN 2=ALARM, word history since (re)start, FIFO contents
    int          m_state;
    logic [15:0] hist[$];
    logic [15:0] m_fifo[$];
    int          m_ovf;
    logic [1:0]  m_cause;
    bit          used[logic [15:0]];

    function automatic logic [15:0] fresh_word();
        logic [15:0] w;
        w = 16'h0;
        for (int t = 0; t < 1000; t++) begin
            w = 16'($urandom);
            if (!used.exists(w) && w != 16'h00FF && w != 16'h1234 && w != 16'hA5A5) break;
        end
        used[w] = 1'b1;
        return w;
    endfunction

    function automatic logic [15:0] m_head();
        return (m_fifo.size() > 0) ? m_fifo[0] : 16'h0000;
    endfunction

    task automatic model_reset();
        m_state = 0;
        hist.delete();
        m_fifo.delete();
        m_ovf = 0;
        m_cause = 2'b00;
    endtask

    task automatic model_edge(input logic iv, input logic [15:0] id, input logic ord, input logic clr);
        bit pop_now, full_old, rf, af;
        int n, ws, c;
        pop_now  = (m_fifo.size() > 0) && ord;
        full_old = (m_fifo.size() == FD);
        if (m_state == 2) begin
            if (clr) begin
                m_state = 0;
                hist.delete();
                m_cause = 2'b00;
            end
            return;
        end
        if (pop_now) void'(m_fifo.pop_front());
        if (!iv) return;
        hist.push_back(id);
        n = hist.size();
        rf = (n >= RCT);
        if (rf) for (int k = n - RCT; k < n; k++) if (hist[k] !== id) rf = 1'b0;
        ws = ((n - 1) / AW) * AW;
        c = 0;
        for (int k = ws; k < n; k++) if (hist[k] === hist[ws]) c++;
        af = (c >= AC);
        if (rf || af) begin
            m_state = 2;
            m_cause = {af, rf};
            m_fifo.delete();
        end else if (m_state == 0) begin
            if (n >= SW) m_state = 1;
        end else if (full_old) begin
            if (m_ovf < 255) m_ovf++;
        end else begin
            m_fifo.push_back(id);
        end
    endtask

    task automatic step(input logic iv, input logic [15:0] id, input logic ord, input logic clr);
        bus_if.in_valid  = iv;
        bus_if.in_data   = id;
        bus_if.out_ready = ord;
        clear_alarm      = clr;
        @(posedge clk);
        model_edge(iv, id, ord, clr);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        n_total++; if (bus_if.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", bus_if.out_valid); else n_pass++;
        n_total++; if (bus_if.out_data !== 16'h0) $display("FAIL reset_out_data: got %h expected 0000", bus_if.out_data); else n_pass++;
        n_total++; if (alarm !== 1'b0) $display("FAIL reset_alarm: got %b expected 0", alarm); else n_pass++;
        n_total++; if (alarm_cause !== 2'b00) $display("FAIL reset_cause: got %b expected 00", alarm_cause); else n_pass++;
        n_total++; if (healthy !== 1'b0) $display("FAIL reset_healthy: got %b expected 0", healthy); else n_pass++;
        n_total++; if (overflow_cnt !== 8'd0) $display("FAIL reset_ovf: got %0d expected 0", overflow_cnt); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_startup_gating();
        for (int i = 0; i < SW; i++) begin
            step(1'b1, fresh_word(), 1'b1, 1'b0);
            n_total++; if (bus_if.out_valid !== 1'b0) $display("FAIL gate_valid[%0d]: got %b expected 0", i, bus_if.out_valid); else n_pass++;
            n_total++; if (healthy !== (i == SW - 1)) $display("FAIL gate_healthy[%0d]: got %b expected %b", i, healthy, (i == SW - 1)); else n_pass++;
        end
        step(1'b1, 16'hA5A5, 1'b1, 1'b0);
        n_total++; if (bus_if.out_valid !== 1'b1) $display("FAIL gate_first_valid: got %b expected 1", bus_if.out_valid); else n_pass++;
        n_total++; if (bus_if.out_data !== 16'hA5A5) $display("FAIL gate_first_data: got %h expected a5a5", bus_if.out_data); else n_pass++;
    endtask

    task automatic test_rct();
        for (int k = 0; k < RCT; k++) begin
            step(1'b1, 16'h1234, 1'b1, 1'b0);
            if (k < RCT - 1) begin
                n_total++; if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== 16'h1234) $display("FAIL rct_deliver[%0d]: got %b/%h expected 1/1234", k, bus_if.out_valid, bus_if.out_data); else n_pass++;
                n_total++; if (alarm !== 1'b0) $display("FAIL rct_early_alarm[%0d]: got %b expected 0", k, alarm); else n_pass++;
            end
        end
        n_total++; if (alarm !== 1'b1) $display("FAIL rct_alarm: got %b expected 1", alarm); else n_pass++;
        n_total++; if (alarm_cause !== 2'b01) $display("FAIL rct_cause: got %b expected 01", alarm_cause); else n_pass++;
        n_total++; if (bus_if.out_valid !== 1'b0) $display("FAIL rct_flush: got %b expected 0", bus_if.out_valid); else n_pass++;
        n_total++; if (healthy !== 1'b0) $display("FAIL rct_healthy: got %b expected 0", healthy); else n_pass++;
    endtask

    task automatic test_clear_restart();
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 16'h1234, 1'b1, 1'b0);
            n_total++; if (alarm !== 1'b1) $display("FAIL hold_alarm[%0d]: got %b expected 1", k, alarm); else n_pass++;
        end
        step(1'b1, fresh_word(), 1'b1, 1'b1);
        n_total++; if (alarm !== 1'b0 || alarm_cause !== 2'b00) $display("FAIL clear_alarm: got %b/%b expected 0/00", alarm, alarm_cause); else n_pass++;
        n_total++; if (healthy !== 1'b0) $display("FAIL clear_healthy: got %b expected 0", healthy); else n_pass++;
        for (int i = 0; i < SW; i++) begin
            step(1'b1, fresh_word(), 1'b1, 1'b0);
            n_total++; if (healthy !== (i == SW - 1)) $display("FAIL restart_healthy[%0d]: got %b expected %b", i, healthy, (i == SW - 1)); else n_pass++;
            n_total++; if (bus_if.out_valid !== 1'b0) $display("FAIL restart_valid[%0d]: got %b expected 0", i, bus_if.out_valid); else n_pass++;
        end
        n_total++; if (overflow_cnt !== 8'(m_ovf)) $display("FAIL restart_ovf: got %0d expected %0d", overflow_cnt, m_ovf); else n_pass++;
    endtask

    task automatic test_apt();
        for (int i = 0; i < AW - SW; i++) begin
            step(1'b1, fresh_word(), 1'b1, 1'b0);
            n_total++; if (alarm !== 1'b0 || bus_if.out_data !== m_head()) $display("FAIL apt_fill[%0d]: got %b/%h expected 0/%h", i, alarm, bus_if.out_data, m_head()); else n_pass++;
        end
        for (int j = 0; j < 2 * AC - 1; j++) begin
            step(1'b1, (j % 2 == 0) ? 16'h00FF : fresh_word(), 1'b1, 1'b0);
            if (j < 2 * AC - 2) begin
                n_total++; if (alarm !== 1'b0) $display("FAIL apt_early[%0d]: got %b expected 0", j, alarm); else n_pass++;
            end
        end
        n_total++; if (alarm !== 1'b1) $display("FAIL apt_alarm: got %b expected 1", alarm); else n_pass++;
        n_total++; if (alarm_cause !== 2'b10) $display("FAIL apt_cause: got %b expected 10", alarm_cause); else n_pass++;
        n_total++; if (bus_if.out_valid !== 1'b0) $display("FAIL apt_flush: got %b expected 0", bus_if.out_valid); else n_pass++;
    endtask

    task automatic test_overflow();
        logic [15:0] exp_w[4];
        logic [15:0] w;
        step(1'b0, 16'h0, 1'b1, 1'b1);
        for (int i = 0; i < SW; i++) step(1'b1, fresh_word(), 1'b1, 1'b0);
        n_total++; if (healthy !== 1'b1) $display("FAIL ovf_run: got %b expected 1", healthy); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            w = fresh_word();
            if (i < 4) exp_w[i] = w;
            step(1'b1, w, 1'b0, 1'b0);
        end
        n_total++; if (overflow_cnt !== 8'd6) $display("FAIL ovf_count: got %0d expected 6", overflow_cnt); else n_pass++;
        n_total++; if (overflow_cnt !== 8'(m_ovf)) $display("FAIL ovf_model: got %0d expected %0d", overflow_cnt, m_ovf); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_total++; if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== exp_w[k]) $display("FAIL ovf_drain[%0d]: got %b/%h expected 1/%h", k, bus_if.out_valid, bus_if.out_data, exp_w[k]); else n_pass++;
            step(1'b0, 16'h0, 1'b1, 1'b0);
        end
        n_total++; if (bus_if.out_valid !== 1'b0) $display("FAIL ovf_empty: got %b expected 0", bus_if.out_valid); else n_pass++;
    endtask

    task automatic test_random();
        logic [15:0] alph[3];
        logic [15:0] id;
        for (int k = 0; k < 3; k++) alph[k] = 16'($urandom);
        for (int c = 0; c < 600; c++) begin
            id = ($urandom_range(0, 1) == 0) ? alph[$urandom_range(0, 2)] : 16'($urandom);
            step(($urandom_range(0, 3) != 0), id, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
            n_total++; if (bus_if.out_valid !== (m_fifo.size() > 0) || bus_if.out_data !== m_head()) $display("FAIL rand_out[%0d]: got %b/%h expected %b/%h", c, bus_if.out_valid, bus_if.out_data, (m_fifo.size() > 0), m_head()); else n_pass++;
            n_total++; if (alarm !== (m_state == 2) || healthy !== (m_state == 1)) $display("FAIL rand_state[%0d]: got alarm %b healthy %b expected state %0d", c, alarm, healthy, m_state); else n_pass++;
            n_total++; if (alarm_cause !== m_cause || overflow_cnt !== 8'(m_ovf)) $display("FAIL rand_status[%0d]: got %b/%0d expected %b/%0d", c, alarm_cause, overflow_cnt, m_cause, m_ovf); else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        logic [15:0] w;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 27; i++) step(1'b1, fresh_word(), 1'b1, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, fresh_word(), 1'b0, 1'b0);
        n_total++; if (bus_if.out_valid !== 1'b1 || healthy !== 1'b1) $display("FAIL mid_pre: got %b/%b expected 1/1", bus_if.out_valid, healthy); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++; if (bus_if.out_valid !== 1'b0 || bus_if.out_data !== 16'h0) $display("FAIL mid_out: got %b/%h expected 0/0000", bus_if.out_valid, bus_if.out_data); else n_pass++;
        n_total++; if (healthy !== 1'b0 || alarm !== 1'b0 || alarm_cause !== 2'b00 || overflow_cnt !== 8'd0) $display("FAIL mid_status: got %b/%b/%b/%0d expected 0/0/00/0", healthy, alarm, alarm_cause, overflow_cnt); else n_pass++;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < SW; i++) begin
            step(1'b1, fresh_word(), 1'b1, 1'b0);
            n_total++; if (bus_if.out_valid !== 1'b0 || healthy !== (i == SW - 1)) $display("FAIL mid_restart[%0d]: got %b/%b expected 0/%b", i, bus_if.out_valid, healthy, (i == SW - 1)); else n_pass++;
        end
        w = fresh_word();
        step(1'b1, w, 1'b1, 1'b0);
        n_total++; if (bus_if.out_valid !== 1'b1 || bus_if.out_data !== w) $display("FAIL mid_first: got %b/%h expected 1/%h", bus_if.out_valid, bus_if.out_data, w); else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_alarm = 1'b0;
        bus_if.in_valid = 1'b0;
        bus_if.in_data = 16'h0;
        bus_if.out_ready = 1'b0;
        model_reset();
        test_reset();
        test_startup_gating();
        test_rct();
        test_clear_restart();
        test_apt();
        test_overflow();
        test_random();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1);
    end
endmodule

// File: doc/trng_health_monitor.md
# trng_health_monitor

Online health monitor and output buffer on the consumer side of the 16-bit TRNG word stream. It runs a repetition-count test (RCT) and an adaptive-proportion test (APT) on every generator word. Words from a healthy source go into a small FIFO with a valid/ready output. On any test failure it latches a sticky alarm and withholds all data until firmware clears the alarm and a fresh startup sequence passes.

## Interface
Parameters:
- RCT_CUTOFF, 4: number of consecutive identical words that constitutes an RCT failure (≥2)
- APT_WINDOW, 64: APT window length in words (power of two, ≥2)
- APT_CUTOFF, 8: matches to the window reference, including the reference itself, that constitutes an APT failure (2..APT_WINDOW)
- STARTUP_WORDS, 16: words that must pass both tests before any data is released (≥1)
- FIFO_DEPTH, 4: output FIFO depth (power of two)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  generator word present this cycle; always accepted, no backpressure
- in_data  in  16  generator word
- out_valid  out  1  FIFO head valid
- out_data  out  16  FIFO head word
- out_ready  in  1  consumer accepts head when out_valid=1
- alarm  out  1  sticky health failure
- alarm_cause  out  2  bit0 = RCT failed, bit1 = APT failed; both bits set if the same word failed both tests
- clear_alarm  in  1  single-cycle pulse; leaves ALARM
- healthy  out  1  high only in RUN
- overflow_cnt  out  8  words dropped because the FIFO was full; saturates at 255

## Operation
- FSM states: STARTUP, RUN, ALARM. Reset state is STARTUP.
- STARTUP: each accepted word is tested but never written to the FIFO. After STARTUP_WORDS words pass consecutively, go to RUN.
- RUN: a passing word is written to the FIFO if the FIFO is not full. Otherwise the word is dropped and overflow_cnt increments (saturating).
- A failing word in STARTUP or RUN is never written. Go to ALARM, set alarm and alarm_cause, and flush the FIFO.
- ALARM: in_valid is ignored and the tests are frozen. A clear_alarm pulse goes to STARTUP, clears alarm and alarm_cause, and resets the RCT, APT and startup counter. overflow_cnt is kept.
- clear_alarm in STARTUP or RUN has no effect.
- RCT: holds last word plus a count.
  - The first word after reset or restart sets count=1.
  - An equal word increments count; a different word sets count=1 and becomes the new last word.
  - Fail when count reaches RCT_CUTOFF.
- APT: holds a window index, a reference word and a match count.
  - The word at index 0 becomes the reference with count=1.
  - Each later word equal to the reference increments count.
  - Fail when count reaches APT_CUTOFF.
  - The word after index APT_WINDOW-1 starts a new window at index 0.
- Both tests see the same word in the same cycle. Failure is evaluated on the updated counts.
- FIFO full/empty use the registered occupancy. A pop in the same cycle does not free space for a push when full. Simultaneous push and pop when not full or empty leaves occupancy unchanged.

## Timing
- Reset values:
  - out_valid=0, out_data=0, alarm=0, alarm_cause=0, healthy=0, overflow_cnt=0.
  - FIFO empty; all test counters and registers 0 with "no last word" state.
- Data latency: a word accepted at edge N is visible on out_valid/out_data after edge N (one cycle) if the FIFO was empty.
- Handshake: a pop occurs on each edge where out_valid and out_ready are both high. out_data is stable while out_valid=1 and out_ready=0.
- Alarm: a failing word accepted at edge N gives alarm=1, healthy=0 and out_valid=0 after edge N.
- State changes: healthy rises after the edge that accepts the STARTUP_WORDS-th passing word. clear_alarm at edge N puts the block in STARTUP after edge N; the word presented at edge N is ignored.
- rst_n low at any time, including mid-window, mid-startup or with the FIFO non-empty, asynchronously forces all reset values.

## Test plan
- Startup gating: 16 distinct words, then word 0xA5A5 → out_valid stays 0 through the first 16; healthy=1 after the 16th; 0xA5A5 appears on out_data one cycle after acceptance.
- RCT failure: in RUN, 0x1234 four times in a row with out_ready=1 → the first three are delivered; alarm=1 and alarm_cause=2'b01 after the fourth; FIFO flushed.
- APT failure: a new window starting 0x00FF, alternating with distinct words (0x00FF, X1, 0x00FF, X2, …) → alarm_cause=2'b10 on the 8th 0x00FF (window index 14); no RCT failure.
- Overflow: RUN, out_ready=0, 10 distinct words → FIFO holds the first 4, overflow_cnt=6; then out_ready=1 → the 4 words drain in order.
- Clear and restart: from ALARM, pulse clear_alarm together with in_valid → that word is ignored; the next 16 passing words restore healthy=1; overflow_cnt unchanged.
- Mid-operation reset: assert rst_n=0 with 3 words buffered and the APT at index 30 → out_valid=0 and all outputs at reset values immediately; after release, 16 words are needed again before any output.
